// File: rtl/edge_capture_pkg.sv
// Shared types for the edge_capture pulse-timing block.
package edge_capture_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

  // Widest counter the result record can hold. Instances narrower than this
  // zero-extend into the record and only expose their own low bits.
  localparam int unsigned CAP_MAX_W = 32;

  // One completed measurement as held in the output register.
  typedef struct packed {
    logic [CAP_MAX_W-1:0] period;
    logic [CAP_MAX_W-1:0] high;
    logic                 sat;
  } cap_res_t;

  // A strobe only counts when the opposite strobe is quiet in the same cycle;
  // both together are treated as noise and ignored.
  function automatic logic clean_strobe(input logic mine, input logic other);
    return mine & ~other;
  endfunction

endpackage

// File: rtl/edge_capture_sat_cnt.sv
// Saturating up-counter with a sticky saturation flag.
// Priority: clear, then load-to-1, then increment.
module sat_cnt #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 load1_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 sat_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 sat_d, sat_q;

  // Next count: the flag is set only when an increment is clipped at the top.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (load1_i) begin
      cnt_d = CNT_ONE;
      sat_d = 1'b0;
    end else if (inc_i) begin
      if (cnt_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/edge_capture.sv
// Pulse-timing capture: measures high time and period of a signal from its
// rising/falling edge strobes and presents each result on a valid/ready port.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | disabled or waiting for the first rising edge; counter held at 0
//  HIGH  | signal high since the last rising edge; waiting for falling edge
//  LOW   | high time captured; next rising edge closes the measurement
module edge_capture
  import edge_capture_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 re_i,
  input  logic                 fe_i,
  input  logic                 clr_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 sat_o,
  output logic                 ovr_o,
  output logic                 busy_o
);

  cap_state_e           state_d, state_q;
  logic [CNT_WIDTH-1:0] hcnt_d, hcnt_q;
  cap_res_t             res_d, res_q;
  logic                 valid_d, valid_q;
  logic                 ovr_d, ovr_q;

  logic                 re_ok, fe_ok;
  logic                 cnt_clr, cnt_load1, cnt_inc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_sat;
  logic                 close;
  logic                 drop;

  assign re_ok   = clean_strobe(re_i, fe_i);
  assign fe_ok   = clean_strobe(fe_i, re_i);
  assign cnt_inc = (state_q != IDLE);

  sat_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .cnt_o   (cnt),
    .sat_o   (cnt_sat)
  );

  // FSM next state, high-time capture and output register/overrun handling.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    res_d     = res_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    close     = 1'b0;
    drop      = 1'b0;

    // Disable aborts the measurement but leaves any pending result alone.
    if (!en_i) begin
      state_d = IDLE;
      hcnt_d  = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (re_ok) begin
            state_d   = HIGH;
            cnt_load1 = 1'b1;
          end
        end
        HIGH: begin
          // A second rising edge without a falling edge means the falling
          // edge was missed; start over from this rising edge.
          if (re_ok) begin
            cnt_load1 = 1'b1;
          end else if (fe_ok) begin
            hcnt_d  = cnt;
            state_d = LOW;
          end
        end
        LOW: begin
          // The closing rising edge also opens the next measurement.
          if (re_ok) begin
            close     = 1'b1;
            cnt_load1 = 1'b1;
            state_d   = HIGH;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    if (close) begin
      if (!valid_q || ready_i) begin
        res_d.period = CAP_MAX_W'(cnt);
        res_d.high   = CAP_MAX_W'(hcnt_q);
        res_d.sat    = cnt_sat;
        valid_d      = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clr_i) begin
      ovr_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // Upper record bits are always zero for narrow instances.
  generate
    if (CNT_WIDTH < CAP_MAX_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^{res_q.period[CAP_MAX_W-1:CNT_WIDTH],
                           res_q.high[CAP_MAX_W-1:CNT_WIDTH]};
    end
  endgenerate

  assign valid_o  = valid_q;
  assign period_o = res_q.period[CNT_WIDTH-1:0];
  assign high_o   = res_q.high[CNT_WIDTH-1:0];
  assign sat_o    = res_q.sat;
  assign ovr_o    = ovr_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_edge_capture.sv
// Bench for edge_capture: a 16-bit and a 4-bit instance share one stimulus
// stream and are checked against a timestamp-based reference model.
module tb_edge_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, re, fe, clr, rdy;

  logic        va, sa, oa, ba;
  logic [15:0] pa, ha;
  logic        vb, sb, ob, bb;
  logic [3:0]  pb, hb;

  edge_capture #(.CNT_WIDTH(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .re_i(re), .fe_i(fe), .clr_i(clr),
    .valid_o(va), .ready_i(rdy), .period_o(pa), .high_o(ha), .sat_o(sa),
    .ovr_o(oa), .busy_o(ba)
  );

  edge_capture #(.CNT_WIDTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .re_i(re), .fe_i(fe), .clr_i(clr),
    .valid_o(vb), .ready_i(rdy), .period_o(pb), .high_o(hb), .sat_o(sb),
    .ovr_o(ob), .busy_o(bb)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: timestamps of the open measurement plus, per instance,
  // the output register contents.
  bit m_open, m_hasfe;
  int m_t0, m_tfe;
  bit mv[2], ms[2], mo[2];
  int mp[2], mh[2];
  int mx[2] = '{65535, 15};

  task automatic model_edge();
    bit newr;
    bit drop;
    int d, dh;
    newr = 1'b0;
    d    = 0;
    dh   = 0;
    if (rst) begin
      m_open  = 1'b0;
      m_hasfe = 1'b0;
      for (int k = 0; k < 2; k++) begin
        mv[k] = 1'b0; ms[k] = 1'b0; mo[k] = 1'b0; mp[k] = 0; mh[k] = 0;
      end
    end else begin
      if (!en) begin
        m_open  = 1'b0;
        m_hasfe = 1'b0;
      end else if (re && !fe) begin
        if (m_open && m_hasfe) begin
          newr = 1'b1;
          d    = cyc - m_t0;
          dh   = m_tfe - m_t0;
        end
        m_open  = 1'b1;
        m_t0    = cyc;
        m_hasfe = 1'b0;
      end else if (fe && !re && m_open && !m_hasfe) begin
        m_hasfe = 1'b1;
        m_tfe   = cyc;
      end
      for (int k = 0; k < 2; k++) begin
        drop = newr && mv[k] && !rdy;
        if (newr && (!mv[k] || rdy)) begin
          mp[k] = (d > mx[k]) ? mx[k] : d;
          mh[k] = (dh > mx[k]) ? mx[k] : dh;
          ms[k] = (d > mx[k]);
          mv[k] = 1'b1;
        end else if (mv[k] && rdy) begin
          mv[k] = 1'b0;
        end
        if (drop) mo[k] = 1'b1;
        else if (clr) mo[k] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic e, input logic r, input logic f,
                      input logic rd, input logic c, input logic rs);
    en = e; re = r; fe = f; rdy = rd; clr = c; rst = rs;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  // Body of a measurement after its opening rising edge: falling edge `hi`
  // cycles after it, leaving the caller to apply the closing edge at `per`.
  task automatic pulse_tail(input int per, input int hi);
    run(hi - 1);
    step(1'b1, 1'b0, 1'b1, rdy, 1'b0, 1'b0);
    run(per - hi - 1);
  endtask

  task automatic quiesce();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({va, pa, ha, sa, oa, ba} !== 36'd0) begin
      failures++;
      $display("FAIL reset_a got v=%0b p=%0d h=%0d s=%0b o=%0b b=%0b want all 0", va, pa, ha, sa, oa, ba);
    end
    checks++;
    if ({vb, pb, hb, sb, ob, bb} !== 12'd0) begin
      failures++;
      $display("FAIL reset_b got v=%0b p=%0d h=%0d s=%0b o=%0b b=%0b want all 0", vb, pb, hb, sb, ob, bb);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    quiesce();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run(6);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(12);
    checks++;
    if (va !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got %0b want 0", va);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({va, pa, ha, sa, ba} !== {1'b1, 16'd20, 16'd7, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL basic_result got v=%0b p=%0d h=%0d s=%0b b=%0b want v=1 p=20 h=7 s=0 b=1", va, pa, ha, sa, ba);
    end
    run(1);
    checks++;
    if (va !== 1'b0) begin
      failures++;
      $display("FAIL basic_consumed got valid=%0b want 0", va);
    end
  endtask

  task automatic test_saturation();
    quiesce();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run(4);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(34);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({vb, pb, hb, sb} !== {1'b1, 4'd15, 4'd5, 1'b1}) begin
      failures++;
      $display("FAIL sat_narrow got v=%0b p=%0d h=%0d s=%0b want v=1 p=15 h=5 s=1", vb, pb, hb, sb);
    end
    checks++;
    if ({va, pa, ha, sa} !== {1'b1, 16'd40, 16'd5, 1'b0}) begin
      failures++;
      $display("FAIL sat_wide got v=%0b p=%0d h=%0d s=%0b want v=1 p=40 h=5 s=0", va, pa, ha, sa);
    end
  endtask

  task automatic test_overrun();
    quiesce();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_tail(10, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({va, pa, ha, oa} !== {1'b1, 16'd10, 16'd3, 1'b0}) begin
      failures++;
      $display("FAIL ovr_first got v=%0b p=%0d h=%0d o=%0b want v=1 p=10 h=3 o=0", va, pa, ha, oa);
    end
    pulse_tail(10, 6);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({va, pa, ha, oa} !== {1'b1, 16'd10, 16'd3, 1'b1}) begin
      failures++;
      $display("FAIL ovr_held got v=%0b p=%0d h=%0d o=%0b want v=1 p=10 h=3 o=1", va, pa, ha, oa);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({va, oa} !== 2'b10) begin
      failures++;
      $display("FAIL ovr_clear got v=%0b o=%0b want v=1 o=0", va, oa);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(7);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({oa, ha} !== {1'b1, 16'd3}) begin
      failures++;
      $display("FAIL ovr_clr_vs_drop got o=%0b h=%0d want o=1 h=3", oa, ha);
    end
  endtask

  task automatic test_back_to_back();
    quiesce();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_tail(8, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({va, pa, ha} !== {1'b1, 16'd8, 16'd2}) begin
      failures++;
      $display("FAIL b2b_first got v=%0b p=%0d h=%0d want v=1 p=8 h=2", va, pa, ha);
    end
    pulse_tail(12, 4);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({va, pa, ha, oa} !== {1'b1, 16'd12, 16'd4, 1'b0}) begin
      failures++;
      $display("FAIL b2b_swap got v=%0b p=%0d h=%0d o=%0b want v=1 p=12 h=4 o=0", va, pa, ha, oa);
    end
  endtask

  task automatic test_abort();
    quiesce();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_tail(6, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({ba, va, pa, ha} !== {1'b0, 1'b1, 16'd6, 16'd2}) begin
      failures++;
      $display("FAIL abort_en got b=%0b v=%0b p=%0d h=%0d want b=0 v=1 p=6 h=2", ba, va, pa, ha);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({ba, va, pa, ha, oa} !== 35'd0) begin
      failures++;
      $display("FAIL abort_rst got b=%0b v=%0b p=%0d h=%0d o=%0b want all 0", ba, va, pa, ha, oa);
    end
  endtask

  task automatic test_illegal();
    quiesce();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ba !== 1'b0) begin
      failures++;
      $display("FAIL illegal_idle got busy=%0b want 0", ba);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run(2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run(1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run(3);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run(3);
    checks++;
    if ({va, ba} !== 2'b01) begin
      failures++;
      $display("FAIL illegal_no_result got v=%0b b=%0b want v=0 b=1", va, ba);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({va, pa, ha} !== {1'b1, 16'd10, 16'd4}) begin
      failures++;
      $display("FAIL illegal_restart got v=%0b p=%0d h=%0d want v=1 p=10 h=4", va, pa, ha);
    end
  endtask

  task automatic test_random();
    logic [35:0] exp_a;
    logic [11:0] exp_b;
    int rp;
    int mism;
    mism = 0;
    for (int i = 0; i < 3000; i++) begin
      rp = (i < 1500) ? 6 : 25;
      step(($urandom_range(0, 60) != 0),
           ($urandom_range(0, rp - 1) == 0),
           ($urandom_range(0, rp - 1) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 700) == 0));
      exp_a = {mv[0], mp[0][15:0], mh[0][15:0], ms[0], mo[0], m_open};
      exp_b = {mv[1], mp[1][3:0], mh[1][3:0], ms[1], mo[1], m_open};
      checks++;
      if ({va, pa, ha, sa, oa, ba} !== exp_a) begin
        failures++;
        mism++;
        if (mism < 10)
          $display("FAIL rand_a cyc=%0d got v=%0b p=%0d h=%0d s=%0b o=%0b b=%0b want v=%0b p=%0d h=%0d s=%0b o=%0b b=%0b",
                   cyc, va, pa, ha, sa, oa, ba, mv[0], mp[0], mh[0], ms[0], mo[0], m_open);
      end
      checks++;
      if ({vb, pb, hb, sb, ob, bb} !== exp_b) begin
        failures++;
        mism++;
        if (mism < 10)
          $display("FAIL rand_b cyc=%0d got v=%0b p=%0d h=%0d s=%0b o=%0b b=%0b want v=%0b p=%0d h=%0d s=%0b o=%0b b=%0b",
                   cyc, vb, pb, hb, sb, ob, bb, mv[1], mp[1], mh[1], ms[1], mo[1], m_open);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; re = 1'b0; fe = 1'b0; clr = 1'b0; rdy = 1'b0;
    m_open = 1'b0; m_hasfe = 1'b0; m_t0 = 0; m_tfe = 0;
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; ms[k] = 1'b0; mo[k] = 1'b0; mp[k] = 0; mh[k] = 0;
    end
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
